pipeline_debug_ctrl: RTL
========================

PIPELINE_DEBUG_CTRL -- requirements
Module: pipeline_debug_ctrl

Interface
REQ-001 SHALL have parameter NB_DATA, default 32, instruction/PC width.
REQ-002 SHALL have parameter NB_IADDR, default 8, instruction-memory word-address width.
REQ-003 SHALL have parameter RUN_TIMEOUT, default 65535, maximum cycles of continuous run (used only under REQ-028).
REQ-004 SHALL use one clock; reset is synchronous and active-high. The clock port is clk and the reset port is i_rst.
REQ-005 Ports: clk  in  1  clock; i_rst  in  1  synchronous active-high reset.
REQ-006 Ports: i_rx_data  in  8  received UART byte; i_rx_valid  in  1  one-cycle byte strobe.
REQ-007 Ports: o_tx_data  out  8  byte to transmit; o_tx_valid  out  1  byte valid; i_tx_ready  in  1  transmitter accepts.
REQ-008 Ports: i_pipe_halt  in  1  HALT instruction retired; i_pc  in  NB_DATA  current fetch PC.
REQ-009 Ports: o_pipe_en  out  1  pipeline advance enable; o_pipe_rst  out  1  pipeline reset pulse.
REQ-010 Ports: o_imem_we  out  1  instruction write strobe; o_imem_addr  out  NB_IADDR  word address; o_imem_data  out  NB_DATA  instruction word.
REQ-011 Ports: o_busy  out  1  high in every state except IDLE.

Function
REQ-012 States SHALL be IDLE, LOAD_LEN, LOAD_BYTE, LOAD_WR, RUN, STEP, SEND.
REQ-013 In IDLE, a received byte SHALL decode as: 0x4C 'L' -> LOAD_LEN; 0x43 'C' -> RUN; 0x53 'S' -> STEP; 0x50 'P' -> one-cycle o_pipe_rst pulse, then SEND ack. Any other byte SHALL be ignored.
REQ-014 LOAD_LEN: the next rx byte is word count N. N=0 SHALL go directly to SEND ack. N>0 SHALL clear the word index to 0 and go to LOAD_BYTE.
REQ-015 LOAD_BYTE: bytes SHALL assemble little-endian (first byte = bits 7:0). After the 4th byte, the state SHALL go to LOAD_WR.
REQ-016 LOAD_WR: o_imem_we SHALL be high for exactly one cycle, with o_imem_addr = word index and o_imem_data = the assembled word. The index then increments. After N words, go to SEND ack; otherwise return to LOAD_BYTE.
REQ-017 The word index SHALL wrap modulo 2^NB_IADDR.
REQ-018 Any rx byte arriving in LOAD_WR, RUN, STEP or SEND SHALL be dropped without effect.
REQ-019 RUN: o_pipe_en SHALL be high on every cycle until i_pipe_halt is sampled high.
REQ-020 On the cycle after i_pipe_halt is sampled high, o_pipe_en SHALL go low, i_pc SHALL be captured, and the state SHALL go to SEND with a PC report.
REQ-021 STEP: o_pipe_en SHALL be high for exactly one cycle. i_pc SHALL be captured the following cycle, then the state goes to SEND with a PC report.
REQ-022 If i_pipe_halt is high on entry to RUN, the block SHALL still give exactly one enable cycle before stopping.
REQ-023 SEND ack SHALL transmit the single byte 0x4B 'K'.
REQ-024 SEND PC report SHALL transmit the 4 captured PC bytes, LSB first.
REQ-025 o_tx_valid/o_tx_data SHALL stay stable until i_tx_ready is high. A byte transfers on a cycle with both high; the next byte (or IDLE) follows the cycle after.
REQ-026 o_pipe_en SHALL be low in every state except RUN and STEP.

Reset
REQ-027 On i_rst high at a clock edge, the block SHALL go to IDLE. All outputs SHALL be 0, including o_pipe_en, o_pipe_rst, o_imem_we, o_tx_valid and o_busy. Capture registers, index and counters SHALL clear, and any load, run or transmit in progress SHALL be aborted. i_rst SHALL take priority over every other input.

Configuration
REQ-028 Macro PIPE_CTRL_RUN_TIMEOUT_EN.
- Defined: RUN SHALL count enable cycles. If the count reaches RUN_TIMEOUT with no halt, o_pipe_en SHALL drop, and SEND SHALL transmit error byte 0xEE followed by the 4 PC bytes.
- Undefined: there is no counter, RUN is unbounded, and 0xEE is never sent.

Verification
REQ-029 'L', 0x02, bytes 78 56 34 12 EF BE AD DE -> two we pulses: addr 0 data 0x12345678, addr 1 data 0xDEADBEEF; then tx 0x4B.
REQ-030 'S' with i_pc=0x00000010 -> o_pipe_en high exactly 1 cycle; tx 10 00 00 00.
REQ-031 'C', i_pipe_halt raised after 20 enable cycles, i_pc=0x44 -> o_pipe_en high exactly 20 cycles, low the next cycle; tx 44 00 00 00.
REQ-032 i_tx_ready held low 5 cycles during the ack -> o_tx_valid and 0x4B stay stable; bytes sent during SEND are dropped.
REQ-033 i_rst asserted mid-load after 2 data bytes, then 'L', 0x01 and 4 bytes -> only the new word is written, at addr 0.
REQ-034 With macro defined and RUN_TIMEOUT=8, 'C' with no halt -> exactly 8 enable cycles; tx EE, then the 4 PC bytes.

Source files
------------

// File: rtl/pipeline_debug_ctrl.sv
// UART-driven debug controller: loads instruction memory, runs or single-steps the pipeline, reports PC.
// Optional run watchdog enabled by defining PIPE_CTRL_RUN_TIMEOUT_EN.
module pipeline_debug_ctrl #(
  parameter int NB_DATA     = 32,
  parameter int NB_IADDR    = 8,
  parameter int RUN_TIMEOUT = 65535
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic [7:0]          i_rx_data,
  input  logic                i_rx_valid,
  output logic [7:0]          o_tx_data,
  output logic                o_tx_valid,
  input  logic                i_tx_ready,
  input  logic                i_pipe_halt,
  input  logic [NB_DATA-1:0]  i_pc,
  output logic                o_pipe_en,
  output logic                o_pipe_rst,
  output logic                o_imem_we,
  output logic [NB_IADDR-1:0] o_imem_addr,
  output logic [NB_DATA-1:0]  o_imem_data,
  output logic                o_busy
);

  typedef enum logic [2:0] {IDLE, LOAD_LEN, LOAD_BYTE, LOAD_WR, RUN, STEP, SEND} state_t;
  typedef enum logic [1:0] {SEND_ACK, SEND_PC, SEND_ERR} send_t;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_RST  = 8'h50;
  localparam logic [7:0] BYTE_ACK = 8'h4B;
  localparam logic [7:0] BYTE_ERR = 8'hEE;

  state_t                state_q, state_d;
  send_t                 kind_q, kind_d;
  logic [7:0]            len_q, wcnt_q;
  logic [NB_IADDR-1:0]   idx_q;
  logic [1:0]            byte_cnt_q;
  logic [31:0]           word_q, pc_q;
  logic [2:0]            tx_idx_q, tx_last;
  logic [1:0]            byte_sel;
  logic [7:0]            pc_byte;
  logic                  cap_pend_q, pipe_rst_q;
  logic                  run_timeout;

`ifdef PIPE_CTRL_RUN_TIMEOUT_EN
  logic [31:0] run_cnt_q;
  assign run_timeout = (run_cnt_q == 32'(RUN_TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(RUN_TIMEOUT);
  assign run_timeout    = 1'b0;
`endif

  always_comb begin
    case (kind_q)
      SEND_PC:  tx_last = 3'd3;
      SEND_ERR: tx_last = 3'd4;
      default:  tx_last = 3'd0;
    endcase
  end

  // Error report prefixes 0xEE, so PC bytes sit one slot later in that frame.
  assign byte_sel = (kind_q == SEND_ERR) ? 2'(tx_idx_q - 3'd1) : tx_idx_q[1:0];
  assign pc_byte  = pc_q[{byte_sel, 3'b000} +: 8];

  // NOTE: every output of this block gets a default first so no path leaves a latch.
  always_comb begin
    state_d    = state_q;
    kind_d     = SEND_ACK;
    o_pipe_en  = 1'b0;
    o_imem_we  = 1'b0;
    o_tx_valid = 1'b0;
    o_tx_data  = 8'h00;
    case (state_q)
      IDLE: if (i_rx_valid) begin
        case (i_rx_data)
          CMD_LOAD: state_d = LOAD_LEN;
          CMD_RUN:  state_d = RUN;
          CMD_STEP: state_d = STEP;
          CMD_RST:  state_d = SEND;
          default:  state_d = IDLE;
        endcase
      end
      LOAD_LEN: if (i_rx_valid) state_d = (i_rx_data == 8'h00) ? SEND : LOAD_BYTE;
      LOAD_BYTE: if (i_rx_valid && byte_cnt_q == 2'd3) state_d = LOAD_WR;
      LOAD_WR: begin
        o_imem_we = 1'b1;
        state_d   = (wcnt_q == len_q - 8'd1) ? SEND : LOAD_BYTE;
      end
      RUN: begin
        o_pipe_en = 1'b1;
        if (i_pipe_halt) begin
          state_d = SEND;
          kind_d  = SEND_PC;
        end else if (run_timeout) begin
          state_d = SEND;
          kind_d  = SEND_ERR;
        end
      end
      STEP: begin
        o_pipe_en = 1'b1;
        state_d   = SEND;
        kind_d    = SEND_PC;
      end
      SEND: if (!cap_pend_q) begin
        o_tx_valid = 1'b1;
        case (kind_q)
          SEND_ACK: o_tx_data = BYTE_ACK;
          SEND_ERR: o_tx_data = (tx_idx_q == 3'd0) ? BYTE_ERR : pc_byte;
          default:  o_tx_data = pc_byte;
        endcase
        if (i_tx_ready && tx_idx_q == tx_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      kind_q     <= SEND_ACK;
      len_q      <= '0;
      wcnt_q     <= '0;
      idx_q      <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      pc_q       <= '0;
      tx_idx_q   <= '0;
      cap_pend_q <= 1'b0;
      pipe_rst_q <= 1'b0;
`ifdef PIPE_CTRL_RUN_TIMEOUT_EN
      run_cnt_q  <= '0;
`endif
    end else begin
      pipe_rst_q <= (state_q == IDLE) && i_rx_valid && (i_rx_data == CMD_RST);
      // PC reports wait one cycle in SEND so the PC reflects the last enabled advance.
      if (state_q != SEND && state_d == SEND) begin
        kind_q     <= kind_d;
        cap_pend_q <= (kind_d != SEND_ACK);
        tx_idx_q   <= '0;
      end
      case (state_q)
        LOAD_LEN: if (i_rx_valid) begin
          len_q      <= i_rx_data;
          wcnt_q     <= '0;
          idx_q      <= '0;
          byte_cnt_q <= '0;
        end
        LOAD_BYTE: if (i_rx_valid) begin
          word_q[{byte_cnt_q, 3'b000} +: 8] <= i_rx_data;
          byte_cnt_q <= byte_cnt_q + 2'd1;
        end
        LOAD_WR: begin
          idx_q  <= idx_q + 1'b1;
          wcnt_q <= wcnt_q + 8'd1;
        end
        SEND: begin
          if (cap_pend_q) begin
            pc_q       <= 32'(i_pc);
            cap_pend_q <= 1'b0;
          end else if (i_tx_ready) begin
            tx_idx_q <= tx_idx_q + 3'd1;
          end
        end
        default: ;
      endcase
`ifdef PIPE_CTRL_RUN_TIMEOUT_EN
      run_cnt_q <= (state_q == RUN) ? run_cnt_q + 32'd1 : '0;
`endif
    end
  end

  assign o_pipe_rst  = pipe_rst_q;
  assign o_imem_addr = idx_q;
  assign o_imem_data = NB_DATA'(word_q);
  assign o_busy      = (state_q != IDLE);

endmodule
